// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//
// IF/ID pipeline register that sits between the fetch stage (PC and
// instruction memory) and the decode/register-file stage. It holds its
// contents while the hazard unit requests a stall, and inserts a bubble
// (NOP, valid cleared) when branch/jump resolution requests a flush.
// A consecutive-stall watchdog raises a sticky flag after MAX_STALL
// back-to-back stall cycles.
//
// Optional build macro: IF_ID_STATS_EN
//   defined   -> stall_total / flush_total are saturating event counters
//   undefined -> stall_total / flush_total read constant 0, no counter flops
//
// Ports:
//   clk            in   1        rising-edge clock
//   rst            in   1        synchronous active-high reset
//   instr_in       in   INSTR_W  fetched instruction
//   pc_plus4_in    in   PC_W     PC+4 from fetch
//   valid_in       in   1        fetch slot holds a real instruction
//   stall          in   1        hold request from the hazard unit
//   flush          in   1        squash request (wins over stall)
//   instr_out      out  INSTR_W  registered instruction to decode
//   pc_plus4_out   out  PC_W     registered PC+4 (debug only when invalid)
//   valid_out      out  1        registered valid
//   stall_run      out  CNT_W    current consecutive-stall count (saturating)
//   stall_timeout  out  1        sticky watchdog flag, cleared only by rst
//   stall_total    out  CNT_W    total stall cycles (stats build only)
//   flush_total    out  CNT_W    total flushes (stats build only)
//
// Every output is driven directly by a flop (or a constant).
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus4_in,
  input  logic               valid_in,
  input  logic               stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_plus4_out,
  output logic               valid_out,
  output logic [CNT_W-1:0]   stall_run,
  output logic               stall_timeout,
  output logic [CNT_W-1:0]   stall_total,
  output logic [CNT_W-1:0]   flush_total
);

  // NOP_INSTR is unsigned, so the size cast zero-extends or truncates.
  localparam logic [INSTR_W-1:0] NOP_W     = INSTR_W'(NOP_INSTR);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]   RUN_ARM   = CNT_W'(MAX_STALL - 1);

  // What the register does on the coming edge (reset handled separately).
  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } act_e;

  act_e act;

  always_comb begin
    act = ACT_LOAD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end
  end

  // -------------------------------------------------------------------------
  // Data path: instruction, PC+4, valid
  // -------------------------------------------------------------------------
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q,    pc_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    unique case (act)
      ACT_FLUSH: begin
        instr_d = NOP_W;
        pc_d    = pc_plus4_in;  // kept for debug visibility only
        valid_d = 1'b0;
      end
      ACT_STALL: begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
      end
      default: begin
        instr_d = instr_in;
        pc_d    = pc_plus4_in;
        valid_d = valid_in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_W;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_q;
  assign valid_out    = valid_q;

  // -------------------------------------------------------------------------
  // Consecutive-stall counter and sticky watchdog
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] run_q, run_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    run_d = '0;
    tmo_d = tmo_q;
    if (act == ACT_STALL) begin
      run_d = (run_q == CNT_SAT) ? run_q : run_q + CNT_ONE;
      // Fires on the edge where the run would reach MAX_STALL.
      if (run_q == RUN_ARM) begin
        tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      run_q <= run_d;
      tmo_q <= tmo_d;
    end
  end

  assign stall_run     = run_q;
  assign stall_timeout = tmo_q;

  // -------------------------------------------------------------------------
  // Optional event statistics
  // -------------------------------------------------------------------------
`ifdef IF_ID_STATS_EN
  logic [CNT_W-1:0] stot_q, stot_d;
  logic [CNT_W-1:0] ftot_q, ftot_d;

  always_comb begin
    stot_d = stot_q;
    ftot_d = ftot_q;
    if ((act == ACT_STALL) && (stot_q != CNT_SAT)) begin
      stot_d = stot_q + CNT_ONE;
    end
    if ((act == ACT_FLUSH) && (ftot_q != CNT_SAT)) begin
      ftot_d = ftot_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stot_q <= '0;
      ftot_q <= '0;
    end else begin
      stot_q <= stot_d;
      ftot_q <= ftot_d;
    end
  end

  assign stall_total = stot_q;
  assign flush_total = ftot_q;
`else
  assign stall_total = '0;
  assign flush_total = '0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

  localparam int unsigned IW  = 32;
  localparam int unsigned PW  = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned MS  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW-1:0] SAT = '1;

  logic          clk = 1'b0;
  logic          rst, valid_in, stall, flush;
  logic [IW-1:0] instr_in;
  logic [PW-1:0] pc_plus4_in;
  logic [IW-1:0] instr_out;
  logic [PW-1:0] pc_plus4_out;
  logic          valid_out, stall_timeout;
  logic [CW-1:0] stall_run, stall_total, flush_total;

  if_id_pipe_reg #(
    .INSTR_W   (IW),
    .PC_W      (PW),
    .NOP_INSTR (NOP),
    .MAX_STALL (MS),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .pc_plus4_in   (pc_plus4_in),
    .valid_in      (valid_in),
    .stall         (stall),
    .flush         (flush),
    .instr_out     (instr_out),
    .pc_plus4_out  (pc_plus4_out),
    .valid_out     (valid_out),
    .stall_run     (stall_run),
    .stall_timeout (stall_timeout),
    .stall_total   (stall_total),
    .flush_total   (flush_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
    logic          valid;
    logic [CW-1:0] run;
    logic          tmo;
    logic [CW-1:0] stot;
    logic [CW-1:0] ftot;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: rst > flush > stall > load.
  task automatic model_edge(input logic r, input logic [IW-1:0] ins, input logic [PW-1:0] pc,
                            input logic v, input logic s, input logic f);
    if (r) begin
      m.instr = NOP; m.pc = '0; m.valid = 1'b0;
      m.run = '0; m.tmo = 1'b0; m.stot = '0; m.ftot = '0;
    end else if (f) begin
      m.instr = NOP; m.pc = pc; m.valid = 1'b0; m.run = '0;
      if (m.ftot != SAT) m.ftot = m.ftot + 1'b1;
    end else if (s) begin
      if (m.run == CW'(MS - 1)) m.tmo = 1'b1;
      if (m.run != SAT) m.run = m.run + 1'b1;
      if (m.stot != SAT) m.stot = m.stot + 1'b1;
    end else begin
      m.instr = ins; m.pc = pc; m.valid = v; m.run = '0;
    end
  endtask

  task automatic step(input logic r, input logic [IW-1:0] ins, input logic [PW-1:0] pc,
                      input logic v, input logic s, input logic f);
    exp_t e;
    rst = r; instr_in = ins; pc_plus4_in = pc; valid_in = v; stall = s; flush = f;
    model_edge(r, ins, pc, v, s, f);
    e = m;
`ifndef IF_ID_STATS_EN
    e.stot = '0;
    e.ftot = '0;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk("instr_out",     64'(instr_out),     64'(e.instr));
      chk("pc_plus4_out",  64'(pc_plus4_out),  64'(e.pc));
      chk("valid_out",     64'(valid_out),     64'(e.valid));
      chk("stall_run",     64'(stall_run),     64'(e.run));
      chk("stall_timeout", 64'(stall_timeout), 64'(e.tmo));
      chk("stall_total",   64'(stall_total),   64'(e.stot));
      chk("flush_total",   64'(flush_total),   64'(e.ftot));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [CW-1:0] st_exp, fl_exp;
    rst = 1'b1; instr_in = '0; pc_plus4_in = '0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    m = '{instr: '0, pc: '0, valid: 1'b0, run: '0, tmo: 1'b0, stot: '0, ftot: '0};
    @(negedge clk);

    // Reset, then a single load.
    step(1, 32'hFFFF_FFFF, 32'h10, 1, 0, 0);
    step(1, 32'hFFFF_FFFF, 32'h10, 1, 0, 0);
    chk("reset_instr_nop", 64'(instr_out), 64'(NOP));
    step(0, 32'h2002_0005, 32'h4, 1, 0, 0);
    chk("load_instr", 64'(instr_out), 64'h2002_0005);
    chk("load_pc",    64'(pc_plus4_out), 64'h4);

    // Stall hold for three cycles while input changes.
    step(0, 32'h8C43_0000, 32'h8, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'hA000_0000 + i, 32'h100 + i, 1, 1, 0);
    chk("stall_hold_instr", 64'(instr_out), 64'h8C43_0000);
    chk("stall_run_3",      64'(stall_run), 64'd3);
    step(0, 32'h0022_1820, 32'hC, 1, 0, 0);

    // Flush beats stall.
    step(0, 32'h1111_2222, 32'h10, 1, 1, 1);
    chk("flush_valid", 64'(valid_out), 64'd0);

    // Watchdog: exactly MAX_STALL stalls, then load, flush, reset.
    for (int i = 0; i < 3; i++) step(0, 32'h3333_0000, 32'h14, 1, 1, 0);
    chk("tmo_before", 64'(stall_timeout), 64'd0);
    step(0, 32'h3333_0000, 32'h14, 1, 1, 0);
    chk("tmo_after", 64'(stall_timeout), 64'd1);
    step(0, 32'h4444_0000, 32'h18, 1, 0, 0);
    step(0, 32'h4444_0004, 32'h1C, 1, 0, 1);
    step(1, 32'h4444_0008, 32'h20, 1, 0, 0);

    // Reset mid-stall, then load.
    step(0, 32'h5555_0000, 32'h24, 1, 0, 0);
    step(0, 32'h5555_0004, 32'h28, 1, 1, 0);
    step(0, 32'h5555_0008, 32'h2C, 1, 1, 0);
    step(1, 32'h5555_000C, 32'h30, 1, 1, 1);
    step(0, 32'h6666_0000, 32'h34, 1, 0, 0);

    // Invalid slot loads raw instruction with valid_out=0.
    step(0, 32'hDEAD_BEEF, 32'h38, 0, 0, 0);
    chk("invalid_raw_instr", 64'(instr_out), 64'hDEAD_BEEF);

    // Stats: 5 stalls and 2 flushes after reset.
    step(1, '0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h7000_0000 + i, 32'h40, 1, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 32'h7100_0000 + i, 32'h44, 1, 0, 1);
`ifdef IF_ID_STATS_EN
    st_exp = CW'(5); fl_exp = CW'(2);
`else
    st_exp = '0; fl_exp = '0;
`endif
    chk("stats_stall_total", 64'(stall_total), 64'(st_exp));
    chk("stats_flush_total", 64'(flush_total), 64'(fl_exp));

    // Long stall: stall_run saturates at all-ones.
    for (int i = 0; i < 260; i++) step(0, 32'h8000_0000 + i, 32'h48, 1, 1, 0);
    chk("stall_run_sat", 64'(stall_run), 64'(SAT));

    // Randomised tail with rare resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), $urandom, $urandom, 1'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Next-generation IF/ID pipeline register between fetch and decode, with width parameters for the instruction and PC fields.
- Adds to the basic hold-on-hazard register: flush/bubble insertion, a valid bit, synchronous reset, and a consecutive-stall watchdog.
- Sits between the PC/instruction-memory stage and the decode/register-file stage.
- Stall is driven by the hazard detection unit; flush is driven by branch/jump resolution.

Parameters:
- INSTR_W, 32, instruction field width in bits.
- PC_W, 32, PC+4 field width in bits.
- NOP_INSTR, 32'h0000_0000, instruction value injected on flush or reset; truncated/zero-extended to INSTR_W.
- MAX_STALL, 8, consecutive-stall count that raises stall_timeout; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the stall counters.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- instr_in, in, INSTR_W, fetched instruction.
- pc_plus4_in, in, PC_W, PC+4 from fetch.
- valid_in, in, 1, fetch slot holds a real instruction.
- stall, in, 1, hazard unit hold request (1 = hold).
- flush, in, 1, squash request (1 = insert bubble).
- instr_out, out, INSTR_W, registered instruction to decode.
- pc_plus4_out, out, PC_W, registered PC+4.
- valid_out, out, 1, registered valid.
- stall_run, out, CNT_W, current consecutive-stall count.
- stall_timeout, out, 1, sticky watchdog flag.
- stall_total, out, CNT_W, total stall cycles (optional feature only).
- flush_total, out, CNT_W, total flushes (optional feature only).

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - instr_out = NOP_INSTR, pc_plus4_out = 0, valid_out = 0.
  - stall_run = 0, stall_timeout = 0, stall_total = 0, flush_total = 0.
- No initial blocks are relied on; rst is the only initialisation.
- Priority per edge: rst > flush > stall > load.
- Load (stall=0, flush=0):
  - instr_out <= instr_in, pc_plus4_out <= pc_plus4_in, valid_out <= valid_in.
  - Latency is 1 cycle.
- Stall (stall=1, flush=0): all three data outputs hold their previous values; inputs are ignored.
- Flush (flush=1, with or without stall):
  - instr_out <= NOP_INSTR, valid_out <= 0.
  - pc_plus4_out <= pc_plus4_in, kept for debug; decode must not use it when valid_out=0.
  - Flush overrides a simultaneous stall; the bubble is inserted regardless.
- stall_run:
  - Increments on each stall=1 & flush=0 edge, saturating at 2^CNT_W-1.
  - Clears to 0 on any edge with stall=0 or flush=1.
- stall_timeout:
  - Set on the edge at which stall_run would reach MAX_STALL, i.e. stall_run == MAX_STALL-1 and a stall edge occurs.
  - Remains 1 until rst; it is never cleared by a load or flush.
- Reset mid-stall or mid-flush: the rst values win on that edge; the next edge behaves normally.
- valid_in=0 with load: the register loads instr_in as given (no NOP substitution), with valid_out=0.
- All outputs come directly from flops; there is no combinational input-to-output path.

Optional Feature:
- Macro: IF_ID_STATS_EN.
- Defined:
  - stall_total increments on every stall=1 & flush=0 edge.
  - flush_total increments on every flush=1 edge.
  - Both saturate at 2^CNT_W-1 and clear on rst.
- Undefined: stall_total and flush_total are tied to 0, with no counter flops; all other behaviour is identical.

Test Plan:
- Reset then load: rst=1 for 2 cycles → instr_out=0, valid_out=0; then instr_in=32'h2002_0005, pc_plus4_in=4, valid_in=1 → one edge later instr_out=32'h2002_0005, pc_plus4_out=4, valid_out=1.
- Stall hold: after a load of 32'h8C43_0000/PC 8, stall=1 for 3 cycles while instr_in changes → outputs stay 32'h8C43_0000/8, stall_run steps 1, 2, 3; stall drops → next instruction loads, stall_run=0.
- Flush beats stall: stall=1 and flush=1 on the same edge with valid_in=1 → instr_out=NOP_INSTR, valid_out=0, stall_run=0, flush_total +1 (with the macro defined).
- Watchdog: MAX_STALL=4, stall held for 4 edges → stall_timeout=1 after the 4th edge; release stall and load → stall_timeout stays 1; rst → 0.
- Reset mid-stall: stall=1 with stall_run=2, then rst=1 for one edge → all outputs at reset values; following load edge captures new data.
- Stats build: with IF_ID_STATS_EN, 5 stall edges and 2 flush edges → stall_total=5, flush_total=2; without the macro, both read 0.
